// File: rtl/fifo_sc_flags_if.sv
// Handshake, data and status bundle for fifo_sc_flags; the FIFO takes the slave side,
// the producer/consumer logic takes the master side.
interface fifo_sc_flags_if #(
    parameter int DSIZE = 8,
    parameter int ASIZE = 4
);
    logic             clr;
    logic [DSIZE-1:0] wdata;
    logic             winc;
    logic             rinc;
    logic [DSIZE-1:0] rdata;
    logic             rvalid;
    logic             wfull;
    logic             rempty;
    logic             walmost_full;
    logic             ralmost_empty;
    logic [ASIZE:0]   count;
    logic             overflow;
    logic             underflow;

    modport master (
        output clr, wdata, winc, rinc,
        input  rdata, rvalid, wfull, rempty, walmost_full, ralmost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  clr, wdata, winc, rinc,
        output rdata, rvalid, wfull, rempty, walmost_full, ralmost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/fifo_sc_flags.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty thresholds, sticky
// overflow/underflow flags and synchronous clear. Define FIFO_FWFT_EN for first-word-fall-through.
module fifo_sc_flags #(
    parameter int DSIZE    = 8,
    parameter int ASIZE    = 4,
    parameter int AF_LEVEL = 12,
    parameter int AE_LEVEL = 2
) (
    input logic            clk,
    input logic            rst_n,
    fifo_sc_flags_if.slave bus
);
    localparam int             DEPTH    = 2 ** ASIZE;
    localparam logic [ASIZE:0] LP_DEPTH = (ASIZE + 1)'(DEPTH);
    localparam logic [ASIZE:0] LP_AF    = (ASIZE + 1)'(AF_LEVEL);
    localparam logic [ASIZE:0] LP_AE    = (ASIZE + 1)'(AE_LEVEL);

    logic [DSIZE-1:0] r_mem [DEPTH];
    logic [ASIZE-1:0] r_wptr;
    logic [ASIZE-1:0] r_rptr;
    logic [ASIZE:0]   r_count;
    logic             r_overflow;
    logic             r_underflow;

    logic w_full;
    logic w_empty;
    logic w_wr_acc;
    logic w_rd_acc;

    // Every flag decodes from the registered count only, so no input reaches an output.
    assign w_full  = (r_count == LP_DEPTH);
    assign w_empty = (r_count == '0);

    // A clear in the same cycle wins over both requests.
    assign w_wr_acc = bus.winc & ~w_full  & ~bus.clr;
    assign w_rd_acc = bus.rinc & ~w_empty & ~bus.clr;

    // NOTE: state registers use non-blocking assignments so every always_ff sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (bus.clr) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) r_wptr <= r_wptr + ASIZE'(1);
            if (w_rd_acc) r_rptr <= r_rptr + ASIZE'(1);
            r_count <= r_count + (ASIZE + 1)'(w_wr_acc) - (ASIZE + 1)'(w_rd_acc);
            if (bus.winc && w_full)  r_overflow  <= 1'b1;
            if (bus.rinc && w_empty) r_underflow <= 1'b1;
        end
    end

`ifdef FIFO_FWFT_EN
    // The array is visible on rdata whenever non-empty, so it resets to give rdata = 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_wr_acc) begin
            r_mem[r_wptr] <= bus.wdata;
        end
    end

    assign bus.rdata  = r_mem[r_rptr];
    assign bus.rvalid = ~w_empty;
`else
    logic [DSIZE-1:0] r_rdata;
    logic             r_rvalid;

    // NOTE: storage has no reset; only pointers and count define valid contents, which keeps it plain RAM.
    always_ff @(posedge clk) begin
        if (w_wr_acc) r_mem[r_wptr] <= bus.wdata;
    end

    // rdata holds across idle cycles and clear; rvalid marks the cycle after each accepted read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else if (bus.clr) begin
            r_rvalid <= 1'b0;
        end else if (w_rd_acc) begin
            r_rdata  <= r_mem[r_rptr];
            r_rvalid <= 1'b1;
        end else begin
            r_rvalid <= 1'b0;
        end
    end

    assign bus.rdata  = r_rdata;
    assign bus.rvalid = r_rvalid;
`endif

    assign bus.count         = r_count;
    assign bus.wfull         = w_full;
    assign bus.rempty        = w_empty;
    assign bus.walmost_full  = (r_count >= LP_AF);
    assign bus.ralmost_empty = (r_count <= LP_AE);
    assign bus.overflow      = r_overflow;
    assign bus.underflow     = r_underflow;
endmodule

// File: tb/tb_fifo_sc_flags.sv
// Self-checking bench for fifo_sc_flags: directed test-plan sequences plus randomized traffic,
// all compared against a queue-based reference model after every clock edge.
module tb_fifo_sc_flags;
    localparam int DSIZE    = 8;
    localparam int ASIZE    = 4;
    localparam int DEPTH    = 16;
    localparam int AF_LEVEL = 12;
    localparam int AE_LEVEL = 2;

    logic clk;
    logic rst_n;

    fifo_sc_flags_if #(.DSIZE(DSIZE), .ASIZE(ASIZE)) bus ();

    fifo_sc_flags #(
        .DSIZE   (DSIZE),
        .ASIZE   (ASIZE),
        .AF_LEVEL(AF_LEVEL),
        .AE_LEVEL(AE_LEVEL)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the FIFO contents as a queue plus the sticky flags and read register.
    logic [DSIZE-1:0] m_q[$];
    logic             m_ovf;
    logic             m_unf;
    logic             m_rvalid;
    logic [DSIZE-1:0] m_rdata;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ovf    = 1'b0;
        m_unf    = 1'b0;
        m_rvalid = 1'b0;
        m_rdata  = '0;
    endtask

    task automatic model_edge(input bit w, input bit r, input logic [DSIZE-1:0] d, input bit c);
        bit full, empty;
        if (c) begin
            m_q.delete();
            m_ovf    = 1'b0;
            m_unf    = 1'b0;
            m_rvalid = 1'b0;
        end else begin
            full  = (m_q.size() == DEPTH);
            empty = (m_q.size() == 0);
            if (w && full)  m_ovf = 1'b1;
            if (r && empty) m_unf = 1'b1;
            m_rvalid = 1'b0;
            if (r && !empty) begin
                m_rdata  = m_q.pop_front();
                m_rvalid = 1'b1;
            end
            if (w && !full) m_q.push_back(d);
        end
    endtask

    task automatic compare_all();
        int n;
        n = m_q.size();
        check("count",         32'(bus.count),     32'(n));
        check("wfull",         32'(bus.wfull),     32'(n == DEPTH));
        check("rempty",        32'(bus.rempty),    32'(n == 0));
        check("walmost_full",  32'(bus.walmost_full),  32'(n >= AF_LEVEL));
        check("ralmost_empty", 32'(bus.ralmost_empty), 32'(n <= AE_LEVEL));
        check("overflow",      32'(bus.overflow),  32'(m_ovf));
        check("underflow",     32'(bus.underflow), 32'(m_unf));
`ifdef FIFO_FWFT_EN
        check("rvalid", 32'(bus.rvalid), 32'(n != 0));
        if (n != 0) check("rdata", 32'(bus.rdata), 32'(m_q[0]));
`else
        check("rvalid", 32'(bus.rvalid), 32'(m_rvalid));
        check("rdata",  32'(bus.rdata),  32'(m_rdata));
`endif
    endtask

    // Inputs change just after a falling edge; model and DUT both react to the next rising edge.
    task automatic step(input bit w, input bit r, input logic [DSIZE-1:0] d, input bit c);
        bus.winc  = w;
        bus.rinc  = r;
        bus.wdata = d;
        bus.clr   = c;
        @(posedge clk);
        model_edge(w, r, d, c);
        @(negedge clk);
        compare_all();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rdata"},  32'(bus.rdata),         32'h0);
        check({tag, "_rvalid"}, 32'(bus.rvalid),        32'h0);
        check({tag, "_wfull"},  32'(bus.wfull),         32'h0);
        check({tag, "_rempty"}, 32'(bus.rempty),        32'h1);
        check({tag, "_count"},  32'(bus.count),         32'h0);
        check({tag, "_af"},     32'(bus.walmost_full),  32'h0);
        check({tag, "_ae"},     32'(bus.ralmost_empty), 32'h1);
        check({tag, "_ovf"},    32'(bus.overflow),      32'h0);
        check({tag, "_unf"},    32'(bus.underflow),     32'h0);
    endtask

    initial begin
        int peak;
        int pw, pr;
        int wr_val;

        rst_n     = 1'b0;
        bus.clr   = 1'b0;
        bus.winc  = 1'b0;
        bus.rinc  = 1'b0;
        bus.wdata = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;

        // Fill 0x01..0x10, then a rejected 17th write of 0x11.
        for (int i = 1; i <= DEPTH; i++) begin
            step(1'b1, 1'b0, DSIZE'(i), 1'b0);
            if (i == 11) check("af_before_12", 32'(bus.walmost_full), 32'h0);
            if (i == 12) check("af_at_12",     32'(bus.walmost_full), 32'h1);
        end
        check("fill_wfull", 32'(bus.wfull), 32'h1);
        check("fill_count", 32'(bus.count), 32'd16);
        step(1'b1, 1'b0, 8'h11, 1'b0);
        check("ovf_17th",   32'(bus.overflow), 32'h1);
        check("count_17th", 32'(bus.count),    32'd16);

        // Drain: 0x01..0x10 in order, then an underflowing read.
        for (int i = 1; i <= DEPTH; i++) begin
            step(1'b0, 1'b1, '0, 1'b0);
`ifndef FIFO_FWFT_EN
            check("drain_rdata", 32'(bus.rdata), 32'(i));
`endif
        end
        check("drain_rempty", 32'(bus.rempty), 32'h1);
        step(1'b0, 1'b1, '0, 1'b0);
        check("unf_set", 32'(bus.underflow), 32'h1);
        step(1'b0, 1'b0, '0, 1'b1);

        // Simultaneous access at count 8, then at full.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, DSIZE'(8'h40 + i), 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1, DSIZE'(8'h50 + i), 1'b0);
            check("simul_count8", 32'(bus.count), 32'd8);
        end
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, DSIZE'(8'h60 + i), 1'b0);
        step(1'b1, 1'b1, 8'hEE, 1'b0);
        check("full_simul_count", 32'(bus.count),    32'd15);
        check("full_simul_ovf",   32'(bus.overflow), 32'h1);

        // Clear with a concurrent write from count 5 with overflow set.
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, '0, 1'b0);
        check("pre_clr_count", 32'(bus.count), 32'd5);
        step(1'b1, 1'b0, 8'h77, 1'b1);
        check("clr_count",  32'(bus.count),    32'd0);
        check("clr_rempty", 32'(bus.rempty),   32'h1);
        check("clr_ovf",    32'(bus.overflow), 32'h0);

        // Wrap-around: 40 words with reads lagging three cycles.
        peak = 0;
        for (int i = 0; i < 43; i++) begin
            step(i < 40, i >= 3, DSIZE'(i), 1'b0);
            if (int'(bus.count) > peak) peak = int'(bus.count);
        end
        check("wrap_peak",  32'(peak),          32'd3);
        check("wrap_empty", 32'(bus.rempty),    32'h1);
        check("wrap_ovf",   32'(bus.overflow),  32'h0);
        check("wrap_unf",   32'(bus.underflow), 32'h0);

`ifdef FIFO_FWFT_EN
        step(1'b1, 1'b0, 8'hA5, 1'b0);
        check("fwft_rdata",  32'(bus.rdata),  32'hA5);
        check("fwft_rvalid", 32'(bus.rvalid), 32'h1);
        step(1'b0, 1'b1, '0, 1'b0);
        check("fwft_rempty", 32'(bus.rempty), 32'h1);
`endif

        // Randomized traffic with shifting write/read bias and occasional clear.
        for (int ph = 0; ph < 8; ph++) begin
            case (ph % 4)
                0: begin pw = 85; pr = 20; end
                1: begin pw = 20; pr = 85; end
                2: begin pw = 50; pr = 50; end
                default: begin pw = 80; pr = 80; end
            endcase
            for (int i = 0; i < 100; i++) begin
                wr_val = int'($urandom_range(0, 255));
                step($urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr,
                     DSIZE'(wr_val), $urandom_range(0, 63) == 0);
            end
        end

        // Asynchronous reset dropped between edges while data is in flight.
        for (int i = 0; i < 6; i++) step(1'b1, i[0], DSIZE'(8'hC0 + i), 1'b0);
        bus.winc = 1'b1;
        bus.rinc = 1'b1;
        #2 rst_n = 1'b0;
        #1 check_reset_values("async_rst");
        model_reset();
        bus.winc = 1'b0;
        bus.rinc = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        compare_all();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, DSIZE'(8'h90 + i), 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, '0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fifo_sc_flags.md
# fifo_sc_flags

Single-clock, parameterised synchronous FIFO for the TinyTapeout FIFO tile family. It replaces the dual-clock divider-based buffer where both sides share `clk`. Over that buffer it adds:
- an occupancy count,
- programmable almost-full and almost-empty thresholds,
- sticky overflow and underflow error flags,
- a synchronous clear.

It sits between the `ui_in` write path and the `uo_out` read path, with status on `uio_out`.

## Interface
Parameters:
- `DSIZE`, 8, data width in bits.
- `ASIZE`, 4, address width; depth `DEPTH = 2**ASIZE`.
- `AF_LEVEL`, 12, `walmost_full` asserts when count ≥ `AF_LEVEL` (legal range 1..DEPTH).
- `AE_LEVEL`, 2, `ralmost_empty` asserts when count ≤ `AE_LEVEL` (legal range 0..DEPTH-1).

Ports:
- `clk` in 1: single clock. All state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `clr` in 1: synchronous clear, active-high.
- `wdata` in DSIZE: write data.
- `winc` in 1: write request.
- `rinc` in 1: read request.
- `rdata` out DSIZE: read data.
- `rvalid` out 1: `rdata` holds freshly read data (standard mode only; see Configuration).
- `wfull` out 1: count == DEPTH.
- `rempty` out 1: count == 0.
- `walmost_full` out 1: count ≥ AF_LEVEL.
- `ralmost_empty` out 1: count ≤ AE_LEVEL.
- `count` out ASIZE+1: current occupancy, 0..DEPTH.
- `overflow` out 1: sticky; a write was attempted while full.
- `underflow` out 1: sticky; a read was attempted while empty.

## Operation
- Storage is a DEPTH×DSIZE register array. Write and read pointers are ASIZE bits and wrap modulo DEPTH.
- Write accepted (`w_acc`) = `winc & ~wfull`. On accept: `mem[wptr] <= wdata`, then `wptr` increments.
- Read accepted (`r_acc`) = `rinc & ~rempty`. On accept, `rptr` increments.
- Acceptance uses flag values from before the edge. At full, simultaneous `winc`+`rinc` gives read accepted and write rejected. At empty, simultaneous `winc`+`rinc` gives write accepted and read rejected.
- `count <= count + w_acc - r_acc`, computed in ASIZE+1 bits; it never leaves 0..DEPTH.
- All status outputs decode combinationally from registered `count`, so there are no glitch paths from inputs.
- Sticky flags:
  - `overflow` sets on `winc & wfull`.
  - `underflow` sets on `rinc & rempty`.
  - Both hold until `clr` or reset. A rejected access never changes pointers, count or memory.
- `clr`:
  - Zeroes both pointers, `count`, `overflow`, `underflow` and `rvalid`.
  - Takes priority over `winc`/`rinc` in the same cycle; neither is accepted.
  - Memory contents and `rdata` are not cleared.
- Reset (`rst_n` low, at any time including mid-transfer) forces the same state as `clr` plus `rdata = 0`.
- Reset values of outputs:
  - `rdata` 0, `rvalid` 0, `wfull` 0, `rempty` 1, `count` 0.
  - `walmost_full` 0.
  - `ralmost_empty` 1.
  - `overflow` 0, `underflow` 0.

## Timing
- Status latency: `count` and all flags reflect an accepted access one cycle after the edge that accepts it.
- Standard mode, read path:
  - On an `r_acc` edge, `rdata <= mem[rptr]` and `rvalid <= 1`.
  - On a non-accept edge, `rvalid <= 0` and `rdata` holds.
  - Read latency is 1 cycle from the accepting edge.
- Write-to-read in standard mode:
  - A write accepted at edge N clears `rempty` after edge N.
  - `rinc` is accepted at edge N+1.
  - Data appears on `rdata` after edge N+1.
- Back-to-back accesses: sustained 1 write + 1 read per cycle with count constant, for any 0 < count < DEPTH.

## Configuration
- Macro `FIFO_FWFT_EN`.
- Defined (first-word-fall-through):
  - `rdata = mem[rptr]` combinationally whenever `rempty = 0`.
  - `rinc` acknowledges (pops) the word currently shown.
  - `rvalid = ~rempty`.
  - A word written at edge N is visible on `rdata` after edge N.
  - The `rdata` register is removed; `rdata` reads 0 after reset because the array resets to 0 in this mode only.
- Undefined: standard registered read as in Timing.

## Test plan
- Fill: reset, then write 0x01..0x10 on 16 consecutive cycles.
  - `wfull` = 1 and `count` = 16 after the 16th edge.
  - `walmost_full` rises after the 12th write.
  - A 17th write with 0x11 sets `overflow`, leaves `count` = 16, and 0x11 is never read back.
- Drain: from full, read 16 times.
  - `rdata` sequence is 0x01..0x10 (standard mode: each value one cycle after its read).
  - `rempty` = 1 after the last read.
  - `ralmost_empty` rises when `count` reaches 2.
  - A further `rinc` sets `underflow`.
- Simultaneous access:
  - At `count` = 8, assert `winc`+`rinc` for 10 cycles: `count` stays 8 and the data order is preserved.
  - At full, `winc`+`rinc` for one cycle gives `count` = 15 and sets `overflow`.
- Wrap-around: stream 40 words 0x00..0x27 with reads lagging 3 cycles.
  - All 40 are read in order; `count` peaks at 3; no flag errors.
- Clear and reset:
  - With `count` = 5 and `overflow` = 1, pulse `clr` together with `winc`: `count` = 0, `rempty` = 1, `overflow` = 0, and the write is ignored.
  - Drop `rst_n` asynchronously mid-stream: all outputs reach their reset values without waiting for a clock edge.
- FWFT build (`FIFO_FWFT_EN` defined): write 0xA5 at edge N.
  - `rdata` = 0xA5 and `rvalid` = 1 after edge N with no `rinc`.
  - `rinc` at edge N+1 gives `rempty` = 1.
